// File: rtl/boreal_ads_emulator.sv
// ADS-style SPI ADC emulator: periodic ticks build a status+channel frame read out over SPI (CPOL=0, CPHA=1).
// Optional macro BOREAL_EMU_NOISE_EN XORs an LFSR into the low byte of each channel word.
module boreal_ads_emulator #(
  parameter int SAMPLE_PERIOD = 400000,
  parameter int NUM_CH        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       drdy_n,
  output logic [7:0] overrun_cnt
);
  localparam int FRAME_W = 24 + 24 * NUM_CH;
  localparam int IDX_W   = $clog2(FRAME_W + 1);
  localparam int CNT_W   = $clog2(SAMPLE_PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_RELEASE = CNT_W'(SAMPLE_PERIOD - 9);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(FRAME_W);

  typedef enum logic [1:0] {WAIT_CS_HIGH = 2'd0, IDLE = 2'd1, SHIFT = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [2:0]         sclk_sync_q, cs_sync_q;
  logic [1:0]         mosi_sync_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               running_q, running_d, rdatac_q, rdatac_d;
  logic [19:0]        sample_cnt_q, sample_cnt_d, sample_inc_s;
  logic [FRAME_W-1:0] shift_q, shift_d, frame_s;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [6:0]         cmd_q, cmd_d;
  logic [2:0]         cmd_cnt_q, cmd_cnt_d;
  logic               miso_q, miso_d, drdy_q, drdy_d;
  logic [7:0]         ovr_q, ovr_d;
  logic [23:0]        chan_s;
  logic [7:0]         cmd_byte_s;
  logic               sclk_rise_s, sclk_fall_s, cs_low_s, cs_fall_s, cs_rise_s, mosi_s;
  logic               tick_s, in_prog_s, cmd_done_s;
`ifdef BOREAL_EMU_NOISE_EN
  logic [15:0]        lfsr_q, lfsr_d;
`endif

  // [1] is the synchronised level, [2] its previous value for edge detection
  assign sclk_rise_s  = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall_s  = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_low_s     = ~cs_sync_q[1];
  assign cs_fall_s    = ~cs_sync_q[1] & cs_sync_q[2];
  assign cs_rise_s    = cs_sync_q[1] & ~cs_sync_q[2];
  assign mosi_s       = mosi_sync_q[1];
  assign tick_s       = running_q && (cnt_q == CNT_LAST);
  assign in_prog_s    = cs_low_s && (bit_idx_q != '0);
  assign sample_inc_s = sample_cnt_q + 20'd1;
  assign cmd_byte_s   = {cmd_q, mosi_s};
  assign cmd_done_s   = (state_q == SHIFT) && !cs_rise_s && sclk_fall_s && (cmd_cnt_q == 3'd7);

  // Frame image for the sample about to be published
  always_comb begin
    frame_s = '0;
    chan_s  = '0;
    frame_s[FRAME_W-1 -: 24] = 24'hC00000;
    for (int k = 1; k <= NUM_CH; k++) begin
      chan_s = {4'(k), sample_inc_s};
`ifdef BOREAL_EMU_NOISE_EN
      chan_s[7:0] = chan_s[7:0] ^ lfsr_q[7:0];
`endif
      frame_s[FRAME_W-1-24*k -: 24] = chan_s;
    end
  end

  // Next-state logic: SPI state machine, tick handling and command decode
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    running_d    = running_q;
    rdatac_d     = rdatac_q;
    sample_cnt_d = sample_cnt_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    cmd_d        = cmd_q;
    cmd_cnt_d    = cmd_cnt_q;
    miso_d       = miso_q;
    drdy_d       = drdy_q;
    ovr_d        = ovr_q;
`ifdef BOREAL_EMU_NOISE_EN
    lfsr_d       = lfsr_q;
`endif

    case (state_q)
      WAIT_CS_HIGH: begin
        if (!cs_low_s) state_d = IDLE;
        else           state_d = WAIT_CS_HIGH;
      end
      IDLE: begin
        if (cs_fall_s) state_d = SHIFT;
        else           state_d = IDLE;
      end
      SHIFT: begin
        if (cs_rise_s) begin
          // Abandon the rest of the frame and any partial command byte
          state_d   = IDLE;
          bit_idx_d = '0;
          shift_d   = '0;
          cmd_d     = '0;
          cmd_cnt_d = 3'd0;
          miso_d    = 1'b0;
        end else begin
          if (sclk_rise_s && rdatac_q) begin
            if (bit_idx_q < IDX_LAST) begin
              miso_d    = shift_q[FRAME_W-1];
              shift_d   = shift_q << 1;
              bit_idx_d = bit_idx_q + IDX_W'(1);
            end else begin
              miso_d    = 1'b0;
            end
          end else begin
            miso_d = miso_q;
          end
          if (sclk_rise_s) drdy_d = 1'b1;
          else             drdy_d = drdy_q;
          if (sclk_fall_s) begin
            cmd_d     = cmd_byte_s[6:0];
            cmd_cnt_d = cmd_cnt_q + 3'd1;
          end else begin
            cmd_d     = cmd_q;
          end
        end
      end
      default: state_d = WAIT_CS_HIGH;
    endcase

    if (state_q != SHIFT || !rdatac_q) miso_d = 1'b0;
    else                               miso_d = miso_d;

    if (running_q && cnt_q == CNT_RELEASE) drdy_d = 1'b1;
    else                                   drdy_d = drdy_d;

    if (tick_s) begin
      sample_cnt_d = sample_inc_s;
`ifdef BOREAL_EMU_NOISE_EN
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
      if (in_prog_s) begin
        if (ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
        else                ovr_d = ovr_q;
      end else begin
        shift_d = frame_s;
        drdy_d  = 1'b0;
      end
    end else begin
      sample_cnt_d = sample_cnt_q;
    end

    if (cmd_done_s) begin
      case (cmd_byte_s)
        8'h08: begin
          running_d = 1'b1;
          cnt_d     = '0;
        end
        8'h0A: begin
          running_d = 1'b0;
          drdy_d    = 1'b1;
        end
        8'h10:   rdatac_d = 1'b1;
        8'h11:   rdatac_d = 1'b0;
        default: rdatac_d = rdatac_q;
      endcase
    end else begin
      rdatac_d = rdatac_d;
    end
  end

  // State registers and input synchronisers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_CS_HIGH;
      sclk_sync_q  <= 3'b000;
      cs_sync_q    <= 3'b000;
      mosi_sync_q  <= 2'b00;
      cnt_q        <= '0;
      running_q    <= 1'b1;
      rdatac_q     <= 1'b1;
      sample_cnt_q <= 20'd0;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      cmd_q        <= 7'd0;
      cmd_cnt_q    <= 3'd0;
      miso_q       <= 1'b0;
      drdy_q       <= 1'b1;
      ovr_q        <= 8'd0;
`ifdef BOREAL_EMU_NOISE_EN
      lfsr_q       <= 16'hACE1;
`endif
    end else begin
      state_q      <= state_d;
      sclk_sync_q  <= {sclk_sync_q[1:0], sclk};
      cs_sync_q    <= {cs_sync_q[1:0], cs_n};
      mosi_sync_q  <= {mosi_sync_q[0], mosi};
      cnt_q        <= cnt_d;
      running_q    <= running_d;
      rdatac_q     <= rdatac_d;
      sample_cnt_q <= sample_cnt_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      cmd_q        <= cmd_d;
      cmd_cnt_q    <= cmd_cnt_d;
      miso_q       <= miso_d;
      drdy_q       <= drdy_d;
      ovr_q        <= ovr_d;
`ifdef BOREAL_EMU_NOISE_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  assign miso        = miso_q;
  assign drdy_n      = drdy_q;
  assign overrun_cnt = ovr_q;
endmodule

// File: tb/tb_boreal_ads_emulator.sv
// Directed bench for boreal_ads_emulator with SAMPLE_PERIOD=2048, NUM_CH=8.
module tb_boreal_ads_emulator;
  localparam int P   = 2048;
  localparam int NCH = 8;
  localparam int FW  = 24 + 24 * NCH;
  localparam int H   = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, drdy_n;
  logic [7:0] overrun_cnt;
  int checks = 0;
  int errors = 0;
  int cyc;

  boreal_ads_emulator #(.SAMPLE_PERIOD(P), .NUM_CH(NCH)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .drdy_n(drdy_n), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  // Cycles since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input int n, input logic [7:0] cmd, inout logic [FW-1:0] data,
                          output int t_fall, input bit chk_drdy);
    t_fall = 0;
    for (int i = 0; i < n; i++) begin
      mosi = (i < 8) ? cmd[7-i] : 1'b0;
      sclk = 1'b1;
      wait_cycles(H);
      data = {data[FW-2:0], miso};
      if (chk_drdy && i == 0) check("drdy_high_after_first_rise", {31'd0, drdy_n}, 32'd1);
      sclk = 1'b0;
      t_fall = cyc;
      wait_cycles(H);
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    wait_cycles(4);
  endtask

  task automatic cs_end();
    cs_n = 1'b1;
    wait_cycles(4);
  endtask

  task automatic send_cmd(input logic [7:0] cmd, output int t_fall);
    logic [FW-1:0] d = '0;
    cs_begin();
    spi_bits(8, cmd, d, t_fall, 1'b0);
    cs_end();
  endtask

  task automatic read_frame(output logic [FW-1:0] d, input bit chk_drdy);
    int t;
    d = '0;
    cs_begin();
    spi_bits(FW, 8'h00, d, t, chk_drdy);
    cs_end();
  endtask

  task automatic wait_drdy(input string tag, output int t);
    int n = 0;
    while (drdy_n !== 1'b0 && n < 4000) begin
      wait_cycles(1);
      n++;
    end
    if (drdy_n !== 1'b0) check({tag, "_timeout"}, {31'd0, drdy_n}, 32'd0);
    t = cyc;
  endtask

  function automatic logic [31:0] word(input logic [FW-1:0] d, input int idx);
    return {8'd0, d[FW-1-24*idx -: 24]};
  endfunction

  initial begin
    logic [FW-1:0] d;
    int t, t_end, lows;

    wait_cycles(3);
    check("reset_miso", {31'd0, miso}, 32'd0);
    check("reset_drdy", {31'd0, drdy_n}, 32'd1);
    check("reset_overrun", {24'd0, overrun_cnt}, 32'd0);
    rst_n = 1'b1;

    wait_drdy("first_drdy", t);
    check("first_drdy_cycle", t, 32'd2048);
    read_frame(d, 1'b1);
    check("f1_status", word(d, 0), 32'hC00000);
    check("f1_ch1", word(d, 1), 32'h100001);
    check("f1_ch4", word(d, 4), 32'h400001);
    check("f1_ch8", word(d, 8), 32'h800001);

    wait_drdy("second_drdy", t);
    check("second_drdy_cycle", t, 32'd4096);

    // Partial read held across three ticks: frame 2 must survive
    d = '0;
    cs_begin();
    spi_bits(10, 8'h00, d, t, 1'b0);
    while (cyc < 10250) wait_cycles(1);
    check("overrun_cnt", {24'd0, overrun_cnt}, 32'd3);
    spi_bits(FW - 10, 8'h00, d, t, 1'b0);
    cs_end();
    check("ovr_status", word(d, 0), 32'hC00000);
    check("ovr_ch1", word(d, 1), 32'h100002);
    check("ovr_ch8", word(d, 8), 32'h800002);

    wait_drdy("post_ovr_drdy", t);
    check("post_ovr_drdy_cycle", t, 32'd12288);

    send_cmd(8'h0A, t);
    lows = 0;
    for (int i = 0; i < 3 * P; i++) begin
      wait_cycles(1);
      if (drdy_n === 1'b0) lows++;
    end
    check("stop_no_drdy", lows, 32'd0);

    // Allow for the synchroniser delay between the last SCLK fall and the decode
    send_cmd(8'h08, t_end);
    wait_drdy("start_drdy", t);
    check("start_delay_in_window", {31'd0, ((t - t_end) >= 2048) && ((t - t_end) <= 2056)}, 32'd1);

    send_cmd(8'h11, t);
    wait_drdy("sdatac_drdy", t);
    read_frame(d, 1'b0);
    check("sdatac_miso_zero", {31'd0, |d}, 32'd0);
    send_cmd(8'h10, t);
    wait_drdy("rdatac_drdy", t);
    read_frame(d, 1'b0);
    check("rdatac_status", word(d, 0), 32'hC00000);
    check("rdatac_ch1", word(d, 1), 32'h100009);
    check("rdatac_ch8", word(d, 8), 32'h800009);

    // Reset mid-frame with cs_n held low
    wait_drdy("pre_reset_drdy", t);
    d = '0;
    cs_begin();
    spi_bits(20, 8'h00, d, t, 1'b0);
    rst_n = 1'b0;
    wait_cycles(2);
    check("midreset_miso", {31'd0, miso}, 32'd0);
    check("midreset_drdy", {31'd0, drdy_n}, 32'd1);
    check("midreset_overrun", {24'd0, overrun_cnt}, 32'd0);
    rst_n = 1'b1;
    d = '0;
    spi_bits(16, 8'h00, d, t, 1'b0);
    check("post_reset_miso_zero", {31'd0, |d}, 32'd0);
    cs_end();
    wait_drdy("post_reset_drdy", t);
    check("post_reset_drdy_cycle", t, 32'd2048);
    read_frame(d, 1'b0);
    check("pr_status", word(d, 0), 32'hC00000);
    check("pr_ch1", word(d, 1), 32'h100001);
    check("pr_ch8", word(d, 8), 32'h800001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
